// File: rtl/ifu_exu_ibuf.sv
// Instruction buffer between ifu and exu: a small in-order FIFO of fetched
// instructions, each tagged with a 16/32-bit predecode flag, emptied on pipeline flush.
module ifu_exu_ibuf #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] ifu_ibuf_i_ir,
  input  logic            ifu_ibuf_i_valid,
  output logic            ibuf_ifu_o_ready,
  output logic [XLEN-1:0] ibuf_exu_o_ir,
  output logic            ibuf_exu_o_ir16,
  output logic            ibuf_exu_o_valid,
  input  logic            exu_ibuf_i_ready,
  input  logic            exu_ibuf_i_flush_req,
  output logic [CW-1:0]   ibuf_o_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [XLEN-1:0]  mem_q [DEPTH];
  logic [DEPTH-1:0] ir16_q;
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  logic full, empty, push, pop, head_live;

  always_comb begin
    full  = (count_q == CW'(DEPTH));
    empty = (count_q == '0);
    // Handshakes depend only on state and flush, never on exu ready.
    ibuf_ifu_o_ready = ~full & ~exu_ibuf_i_flush_req;
    ibuf_exu_o_valid = ~empty & ~exu_ibuf_i_flush_req;
    push = ifu_ibuf_i_valid & ibuf_ifu_o_ready;
    pop  = ibuf_exu_o_valid & exu_ibuf_i_ready;

    vld_d    = vld_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (exu_ibuf_i_flush_req) begin
      vld_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        vld_d[wr_ptr_q] = 1'b1;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        vld_d[rd_ptr_q] = 1'b0;
        rd_ptr_d        = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end

    head_live       = ~empty & vld_q[rd_ptr_q];
    ibuf_exu_o_ir   = head_live ? mem_q[rd_ptr_q] : '0;
    ibuf_exu_o_ir16 = head_live & ir16_q[rd_ptr_q];
    ibuf_o_count    = count_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      vld_q    <= vld_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage is qualified by the valid bits, so it carries no reset.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (push && (wr_ptr_q == PW'(gi))) begin
        mem_q[gi]  <= ifu_ibuf_i_ir;
        ir16_q[gi] <= (ifu_ibuf_i_ir[1:0] != 2'b11);
      end
    end
  end

endmodule

// File: tb/tb_ifu_exu_ibuf.sv
// Bench for ifu_exu_ibuf: directed scenarios then random traffic, all checked
// against a queue-based model of the buffer's contents.
module tb_ifu_exu_ibuf;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;
  localparam int CW    = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [XLEN-1:0] ifu_ibuf_i_ir;
  logic            ifu_ibuf_i_valid;
  logic            ibuf_ifu_o_ready;
  logic [XLEN-1:0] ibuf_exu_o_ir;
  logic            ibuf_exu_o_ir16;
  logic            ibuf_exu_o_valid;
  logic            exu_ibuf_i_ready;
  logic            exu_ibuf_i_flush_req;
  logic [CW-1:0]   ibuf_o_count;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] model_q[$];

  ifu_exu_ibuf #(.XLEN(XLEN), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .ifu_ibuf_i_ir        (ifu_ibuf_i_ir),
    .ifu_ibuf_i_valid     (ifu_ibuf_i_valid),
    .ibuf_ifu_o_ready     (ibuf_ifu_o_ready),
    .ibuf_exu_o_ir        (ibuf_exu_o_ir),
    .ibuf_exu_o_ir16      (ibuf_exu_o_ir16),
    .ibuf_exu_o_valid     (ibuf_exu_o_valid),
    .exu_ibuf_i_ready     (exu_ibuf_i_ready),
    .exu_ibuf_i_flush_req (exu_ibuf_i_flush_req),
    .ibuf_o_count         (ibuf_o_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, then advance both.
  task automatic cycle(input logic v, input logic [31:0] ir, input logic r, input logic f);
    logic m_ready, m_valid, m_push, m_pop;
    logic [31:0] m_head;
    ifu_ibuf_i_valid     = v;
    ifu_ibuf_i_ir        = ir;
    exu_ibuf_i_ready     = r;
    exu_ibuf_i_flush_req = f;
    #1;
    m_ready = (model_q.size() < DEPTH) && !f;
    m_valid = (model_q.size() > 0) && !f;
    m_head  = (model_q.size() > 0) ? model_q[0] : 32'h0;
    chk("ready", {31'b0, ibuf_ifu_o_ready}, {31'b0, m_ready});
    chk("valid", {31'b0, ibuf_exu_o_valid}, {31'b0, m_valid});
    chk("count", {30'b0, ibuf_o_count}, model_q.size());
    chk("head_ir", ibuf_exu_o_ir, m_head);
    chk("head_ir16", {31'b0, ibuf_exu_o_ir16},
        {31'b0, (model_q.size() > 0) && (m_head[1:0] != 2'b11)});
    m_push = v && m_ready;
    m_pop  = m_valid && r;
    @(posedge clk);
    if (f) model_q.delete();
    else begin
      if (m_pop) void'(model_q.pop_front());
      if (m_push) model_q.push_back(ir);
    end
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    ifu_ibuf_i_valid = 1'b0;
    ifu_ibuf_i_ir = '0;
    exu_ibuf_i_ready = 1'b0;
    exu_ibuf_i_flush_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'b0, ibuf_ifu_o_ready}, 32'd1);
    chk("rst_valid", {31'b0, ibuf_exu_o_valid}, 32'd0);
    chk("rst_count", {30'b0, ibuf_o_count}, 32'd0);
    chk("rst_ir", ibuf_exu_o_ir, 32'd0);
    rst_n = 1'b1;

    // Fill, then a third push must be refused.
    cycle(1'b1, 32'h0000_0093, 1'b0, 1'b0);
    cycle(1'b1, 32'h0000_4501, 1'b0, 1'b0);
    cycle(1'b1, 32'h0000_0113, 1'b0, 1'b0);
    chk("fill_count", {30'b0, ibuf_o_count}, 32'd2);
    chk("fill_head", ibuf_exu_o_ir, 32'h0000_0093);

    // Drain in order.
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    chk("drain1_head", ibuf_exu_o_ir, 32'h0000_4501);
    chk("drain1_ir16", {31'b0, ibuf_exu_o_ir16}, 32'd1);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    chk("drain_count", {30'b0, ibuf_o_count}, 32'd0);
    chk("drain_valid", {31'b0, ibuf_exu_o_valid}, 32'd0);

    // Streaming across pointer wrap.
    for (int i = 1; i <= 8; i++) cycle(1'b1, (i << 2) | 32'h3, 1'b1, 1'b0);
    chk("stream_count", {30'b0, ibuf_o_count}, 32'd1);
    chk("stream_head", ibuf_exu_o_ir, 32'h0000_0023);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // Flush with a simultaneous push attempt.
    cycle(1'b1, 32'h0000_0193, 1'b0, 1'b0);
    cycle(1'b1, 32'h0000_0213, 1'b0, 1'b0);
    cycle(1'b1, 32'h0000_0293, 1'b1, 1'b1);
    chk("flush_count", {30'b0, ibuf_o_count}, 32'd0);
    cycle(1'b1, 32'h0000_0513, 1'b0, 1'b0);
    chk("postflush_head", ibuf_exu_o_ir, 32'h0000_0513);
    cycle(1'b1, 32'h0000_0593, 1'b0, 1'b0);

    // Asynchronous reset between edges while full.
    ifu_ibuf_i_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_ready", {31'b0, ibuf_ifu_o_ready}, 32'd1);
    chk("async_valid", {31'b0, ibuf_exu_o_valid}, 32'd0);
    chk("async_count", {30'b0, ibuf_o_count}, 32'd0);
    chk("async_ir", ibuf_exu_o_ir, 32'd0);
    model_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(3, 0) != 0, $urandom(), $urandom_range(1, 0) == 1,
            $urandom_range(15, 0) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
